// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: sequences EX/MEM loading and the data-memory req/ack access with timeout
module mem_stage_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              flush,
    output logic              exmem_load,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic is_mem, last;

    assign exmem_load = (state == IDLE) & ex_valid & ~flush;
    assign stall      = (state == ACCESS);
    assign is_mem     = ex_mem_read ^ ex_mem_write;
    assign last       = (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = (exmem_load & is_mem) ? ACCESS : IDLE;
        else
            state_nx = (dmem_ack | last) ? IDLE : ACCESS;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            wb_valid   <= 1'b0;
            wb_data    <= '0;
            mem_err    <= 1'b0;
            cnt        <= '0;
        end else begin
            wb_valid <= 1'b0;
            if (state == IDLE) begin
                if (exmem_load) begin
                    if (is_mem) begin
                        dmem_addr <= ex_addr;
                        dmem_we   <= ex_mem_write;
                        dmem_req  <= 1'b1;
                        cnt       <= '0;
                        if (ex_mem_write)
                            dmem_wdata <= ex_wdata;
                    end else if (ex_mem_read) begin
                        mem_err <= 1'b1;
                    end else begin
                        wb_valid <= 1'b1;
                        wb_data  <= DATA_W'(ex_addr);
                    end
                end
            end else if (dmem_ack) begin
                // ack on the final timeout cycle still completes normally
                dmem_req <= 1'b0;
                if (!dmem_we) begin
                    wb_valid <= 1'b1;
                    wb_data  <= dmem_rdata;
                end
            end else if (last) begin
                dmem_req <= 1'b0;
                mem_err  <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
